// File: rtl/node_pkg.sv
// node_pkg: shared widths, operand-field selectors and driver state encoding
package node_pkg;
  localparam int W_DEF = 10;
  localparam logic [1:0] FLD_A  = 2'd0;
  localparam logic [1:0] FLD_B  = 2'd1;
  localparam logic [1:0] FLD_MA = 2'd2;
  localparam logic [1:0] FLD_MB = 2'd3;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, FIN} state_t;
endpackage

// File: rtl/node_operand_table.sv
// node_operand_table: DEPTH x 4 operand register file, one write port, one full-entry read port
module node_operand_table
  import node_pkg::*;
#(
  parameter int WIDTH = W_DEF,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [1:0]               wr_field_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_a_o,
  output logic [WIDTH-1:0]         rd_b_o,
  output logic [WIDTH-1:0]         rd_ma_o,
  output logic [WIDTH-1:0]         rd_mb_o
);
  logic [WIDTH-1:0] mem_q [DEPTH][4];
  // Contents survive reset on purpose: a reset aborts a run, not the loaded job table
  always_ff @(posedge clk)
    if (we_i) mem_q[wr_addr_i][wr_field_i] <= wr_data_i;
  assign rd_a_o  = mem_q[rd_addr_i][FLD_A];
  assign rd_b_o  = mem_q[rd_addr_i][FLD_B];
  assign rd_ma_o = mem_q[rd_addr_i][FLD_MA];
  assign rd_mb_o = mem_q[rd_addr_i][FLD_MB];
endmodule

// File: rtl/node_driver.sv
// node_driver: issues stored operand sets to a node, waits its latency and streams results out
module node_driver
  import node_pkg::*;
#(
  parameter int WIDTH    = W_DEF,
  parameter int DEPTH    = 8,
  parameter int NODE_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [1:0]               wr_field,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   len,
  output logic [WIDTH-1:0]         node_a,
  output logic [WIDTH-1:0]         node_b,
  output logic [WIDTH-1:0]         node_multa,
  output logic [WIDTH-1:0]         node_multb,
  output logic                     node_valid,
  input  logic [WIDTH-1:0]         node_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [$clog2(DEPTH)-1:0] res_idx,
  output logic                     busy,
  output logic                     done
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(NODE_LAT + 1);
  state_t state_q, state_d;
  logic [AW-1:0] idx_q;
  logic [LW-1:0] len_q;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, ma_q, mb_q;
  logic [WIDTH-1:0] rd_a, rd_b, rd_ma, rd_mb;
  logic lat_done, last;
  assign lat_done = cnt_q == CW'(NODE_LAT - 1);
  assign last     = LW'(idx_q) == len_q - LW'(1);
  node_operand_table #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_table (
    .clk       (clk),
    .we_i      (wr_en && state_q == IDLE),
    .wr_addr_i (wr_addr),
    .wr_field_i(wr_field),
    .wr_data_i (wr_data),
    .rd_addr_i (idx_q),
    .rd_a_o    (rd_a),
    .rd_b_o    (rd_b),
    .rd_ma_o   (rd_ma),
    .rd_mb_o   (rd_mb)
  );
  // State register
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  // Next-state: one ISSUE/WAIT/OUT loop per entry, FIN once per run
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len == '0) ? FIN : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (lat_done) state_d = OUT;
      OUT:     if (res_ready) state_d = last ? FIN : ISSUE;
      default: state_d = IDLE;
    endcase
  end
  // Operands come straight from the table during ISSUE so a write in the start cycle is seen
  always_comb begin
    node_valid = state_q == ISSUE;
    busy       = state_q != IDLE;
    done       = state_q == FIN;
    node_a     = node_valid ? rd_a  : a_q;
    node_b     = node_valid ? rd_b  : b_q;
    node_multa = node_valid ? rd_ma : ma_q;
    node_multb = node_valid ? rd_mb : mb_q;
  end
  // Run bookkeeping, operand hold registers, latency counter and result register
  always_ff @(posedge clk)
    if (rst) begin
      idx_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        len_q <= (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
        idx_q <= '0;
      end
      if (state_q == ISSUE) begin
        a_q   <= rd_a;
        b_q   <= rd_b;
        ma_q  <= rd_ma;
        mb_q  <= rd_mb;
        cnt_q <= '0;
      end
      if (state_q == WAIT) begin
        cnt_q <= cnt_q + CW'(1);
        if (lat_done) begin
          res_data  <= node_result;
          res_idx   <= idx_q;
          res_valid <= 1'b1;
        end
      end
      if (state_q == OUT && res_ready) begin
        res_valid <= 1'b0;
        if (!last) idx_q <= idx_q + AW'(1);
      end
    end
endmodule

// File: tb/tb_node_driver.sv
// tb_node_driver: directed checks of node_driver against a 2-cycle behavioural node
module tb_node_driver;
  logic clk = 0, rst = 1;
  logic wr_en = 0, start = 0, res_ready = 0;
  logic [2:0] wr_addr = 0;
  logic [1:0] wr_field = 0;
  logic [9:0] wr_data = 0;
  logic [3:0] len = 0;
  logic [9:0] node_a, node_b, node_multa, node_multb, node_result, res_data;
  logic [2:0] res_idx;
  logic node_valid, res_valid, busy, done;
  logic [9:0] p0, p1;
  int n_chk = 0, n_err = 0, done_cnt = 0, nv_cnt = 0, n;

  node_driver #(.WIDTH(10), .DEPTH(8), .NODE_LAT(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_field(wr_field),
    .wr_data(wr_data), .start(start), .len(len), .node_a(node_a), .node_b(node_b),
    .node_multa(node_multa), .node_multb(node_multb), .node_valid(node_valid),
    .node_result(node_result), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_idx(res_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    p0 <= node_valid ? 10'(node_a * node_multa + node_b * node_multb) : 10'd0;
    p1 <= p0;
    if (done) done_cnt++;
    if (node_valid) nv_cnt++;
  end
  assign node_result = p1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int f, input int d);
    wr_en = 1; wr_addr = 3'(a); wr_field = 2'(f); wr_data = 10'(d);
    tick();
    wr_en = 0;
  endtask

  task automatic wr_entry(input int a, input int va, input int vb, input int vma, input int vmb);
    wr(a, 0, va); wr(a, 1, vb); wr(a, 2, vma); wr(a, 3, vmb);
  endtask

  task automatic go(input int l);
    start = 1; len = 4'(l);
    tick();
    start = 0;
  endtask

  task automatic wait_res(output int cycles);
    cycles = 0;
    while (!res_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    int d0, v0;
    tick(); tick();
    rst = 0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_node_a", node_a, 0);
    chk("rst_res_data", res_data, 0);

    // 1: basic single job, latency and done timing
    wr_entry(0, 3, 4, 5, 6);
    res_ready = 1;
    go(1);
    chk("t1_issue_valid", node_valid, 1);
    chk("t1_issue_a", node_a, 3);
    chk("t1_issue_mb", node_multb, 6);
    tick();
    chk("t1_wait_valid", node_valid, 0);
    chk("t1_hold_ma", node_multa, 5);
    wait_res(n);
    chk("t1_latency", n, 2);
    chk("t1_data", res_data, 39);
    chk("t1_idx", res_idx, 0);
    d0 = done_cnt;
    tick();
    chk("t1_done", done, 1);
    chk("t1_res_valid_clr", res_valid, 0);
    tick();
    chk("t1_done_one", done, 0);
    chk("t1_idle", busy, 0);
    chk("t1_done_cnt", done_cnt, d0 + 1);

    // 2: truncation belongs to the node
    wr_entry(0, 1023, 0, 2, 0);
    go(1);
    wait_res(n);
    chk("t2_latency", n, 3);
    chk("t2_data", res_data, 1022);
    tick(); tick();
    chk("t2_idle", busy, 0);

    // 3: three jobs, stall on idx1
    wr_entry(0, 1, 1, 1, 1);
    wr_entry(1, 2, 2, 2, 2);
    wr_entry(2, 3, 3, 3, 3);
    res_ready = 0;
    d0 = done_cnt;
    go(3);
    for (int k = 0; k < 3; k++) begin
      wait_res(n);
      chk("t3_latency", n, 3);
      chk("t3_data", res_data, (k + 1) * (k + 1) * 2);
      chk("t3_idx", res_idx, k);
      if (k == 1)
        for (int s = 0; s < 5; s++) begin
          tick();
          chk("t3_stall_valid", res_valid, 1);
          chk("t3_stall_data", res_data, 8);
          chk("t3_stall_idx", res_idx, 1);
          chk("t3_stall_no_issue", node_valid, 0);
        end
      res_ready = 1;
      tick();
      res_ready = 0;
      if (k < 2) chk("t3_next_issue", node_valid, 1);
      else chk("t3_done", done, 1);
    end
    tick();
    chk("t3_done_cnt", done_cnt, d0 + 1);
    chk("t3_idle", busy, 0);

    // 4: zero-length run
    d0 = done_cnt; v0 = nv_cnt;
    go(0);
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 1);
    tick();
    chk("t4_done_clr", done, 0);
    chk("t4_busy_clr", busy, 0);
    chk("t4_no_issue", nv_cnt, v0);
    chk("t4_done_cnt", done_cnt, d0 + 1);

    // 5: reset during WAIT of idx1
    res_ready = 1;
    go(3);
    wait_res(n);
    chk("t5_first", res_data, 2);
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    d0 = done_cnt;
    chk("t5_busy", busy, 0);
    chk("t5_node_valid", node_valid, 0);
    chk("t5_node_a", node_a, 0);
    chk("t5_node_b", node_b, 0);
    chk("t5_node_ma", node_multa, 0);
    chk("t5_node_mb", node_multb, 0);
    chk("t5_res_valid", res_valid, 0);
    chk("t5_res_data", res_data, 0);
    chk("t5_res_idx", res_idx, 0);
    chk("t5_done", done, 0);
    for (int s = 0; s < 6; s++) tick();
    chk("t5_no_done", done_cnt, d0);
    go(1);
    wait_res(n);
    chk("t5_rerun_data", res_data, 2);
    chk("t5_rerun_idx", res_idx, 0);
    tick(); tick();

    // 6: start and writes ignored while busy
    wr_entry(0, 3, 4, 5, 6);
    res_ready = 0;
    v0 = nv_cnt;
    go(1);
    wr_en = 1; wr_addr = 0; wr_field = 0; wr_data = 100;
    start = 1; len = 2;
    tick();
    wr_en = 0;
    wait_res(n);
    start = 0;
    chk("t6_data", res_data, 39);
    res_ready = 1;
    tick();
    chk("t6_done", done, 1);
    tick();
    chk("t6_idle", busy, 0);
    chk("t6_one_issue", nv_cnt, v0 + 1);
    go(1);
    wait_res(n);
    chk("t6_table_kept", res_data, 39);
    tick(); tick();

    // 7: len above DEPTH clamps to DEPTH
    for (int i = 0; i < 8; i++) wr_entry(i, i + 10, 0, 1, 0);
    v0 = nv_cnt;
    go(15);
    for (int k = 0; k < 8; k++) begin
      wait_res(n);
      chk("t7_data", res_data, k + 10);
      chk("t7_idx", res_idx, k);
      tick();
    end
    chk("t7_done", done, 1);
    chk("t7_issues", nv_cnt, v0 + 8);
    tick();
    chk("t7_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
